// File: rtl/laser_pkg.sv
// Shared encodings and default constants for the laser echo window block.
package laser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WINDOW = 2'd1,
    ST_RESULT = 2'd2,
    ST_GUARD  = 2'd3
  } state_t;

  localparam int TDC_STOP1_WINDOW = 48;
  localparam int TDC_STOP2_WINDOW = 54;
  localparam int SERNUM_W         = 4;
  localparam int NUM_CH           = 2;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_bits(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/echo_first_hit.sv
// Keeps the first stop pulse of one TDC channel that lands inside its window.
module echo_first_hit
  import laser_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             i_clk_100m,
  input  logic             i_rst,
  input  logic             clr,
  input  logic             arm,
  input  logic [CNT_W-1:0] win_cnt,
  input  logic [CNT_W-1:0] win_lim,
  input  logic             stop,
  output logic             hit,
  output logic [CNT_W-1:0] hit_time
);

  logic take;

  assign take = arm && stop && !hit && (win_cnt < win_lim);

  // The timestamp only moves on the first in-window hit, so it reads 0 on a miss.
  always_ff @(posedge i_clk_100m or posedge i_rst) begin
    if (i_rst) begin
      hit      <= 1'b0;
      hit_time <= '0;
    end else if (clr) begin
      hit      <= 1'b0;
      hit_time <= '0;
    end else if (take) begin
      hit      <= 1'b1;
      hit_time <= win_cnt;
    end
  end

endmodule

// File: rtl/laser_echo_window.sv
// Per-shot echo window: opens stop windows on fire, reports first hits, paces the trigger.
module laser_echo_window
  import laser_pkg::*;
#(
  parameter int STOP1_WIN = TDC_STOP1_WINDOW,
  parameter int STOP2_WIN = TDC_STOP2_WINDOW,
  parameter int GUARD_CYC = 4,
  parameter int CNT_W     = 8
) (
  input  logic                i_clk_100m,
  input  logic                i_rst,
  input  logic                i_laser_sync,
  input  logic [SERNUM_W-1:0] i_laser_sernum,
  input  logic                i_stop1,
  input  logic                i_stop2,
  input  logic                i_result_ready,
  output logic                o_result_valid,
  output logic [SERNUM_W-1:0] o_result_sernum,
  output logic [CNT_W-1:0]    o_stop1_time,
  output logic [CNT_W-1:0]    o_stop2_time,
  output logic                o_stop1_hit,
  output logic                o_stop2_hit,
  output logic                o_cdctdc_ready,
  output logic                o_sync_drop
);

  localparam int G_W = cnt_bits(GUARD_CYC);

  if (STOP1_WIN < 1 || STOP2_WIN < STOP1_WIN || STOP2_WIN > (1 << CNT_W) - 1) begin : g_param_chk
    $error("laser_echo_window: window parameters out of range");
  end

  state_t                          state, state_nxt;
  logic [CNT_W-1:0]                cnt;
  logic [G_W-1:0]                  gcnt;
  logic [SERNUM_W-1:0]             sernum_q;
  logic                            drop_q;
  logic                            start, win_last, xfer, in_win;
  logic [NUM_CH-1:0]               stop_vec, hit_vec;
  logic [NUM_CH-1:0][CNT_W-1:0]    lim_vec, time_vec;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    win_last  = 1'b0;
    xfer      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_laser_sync) begin
          start     = 1'b1;
          state_nxt = ST_WINDOW;
        end
      end
      ST_WINDOW: begin
        if (cnt == CNT_W'(STOP2_WIN - 1)) begin
          win_last  = 1'b1;
          state_nxt = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (i_result_ready) begin
          xfer      = 1'b1;
          state_nxt = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (gcnt == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_GUARD;
    endcase
  end

  always_ff @(posedge i_clk_100m or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_GUARD;
      cnt      <= '0;
      gcnt     <= G_W'(GUARD_CYC);
      sernum_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      drop_q <= i_laser_sync && (state != ST_IDLE);
      if (start) begin
        cnt      <= '0;
        sernum_q <= i_laser_sernum;
      end else if (state == ST_WINDOW && !win_last) begin
        cnt <= cnt + 1'b1;
      end
      if (xfer) begin
        gcnt <= G_W'(GUARD_CYC);
      end else if (state == ST_GUARD && gcnt != '0) begin
        gcnt <= gcnt - 1'b1;
      end
    end
  end

  // Hit registers only change while the window is open, so they double as
  // the stable result register during ST_RESULT.
  assign in_win     = (state == ST_WINDOW);
  assign stop_vec   = {i_stop2, i_stop1};
  assign lim_vec[0] = CNT_W'(STOP1_WIN);
  assign lim_vec[1] = CNT_W'(STOP2_WIN);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    echo_first_hit #(.CNT_W(CNT_W)) u_hit (
      .i_clk_100m (i_clk_100m),
      .i_rst      (i_rst),
      .clr        (start),
      .arm        (in_win),
      .win_cnt    (cnt),
      .win_lim    (lim_vec[g]),
      .stop       (stop_vec[g]),
      .hit        (hit_vec[g]),
      .hit_time   (time_vec[g])
    );
  end

  assign o_result_valid  = (state == ST_RESULT);
  assign o_result_sernum = sernum_q;
  assign o_stop1_hit     = hit_vec[0];
  assign o_stop2_hit     = hit_vec[1];
  assign o_stop1_time    = time_vec[0];
  assign o_stop2_time    = time_vec[1];
  assign o_cdctdc_ready  = (state == ST_IDLE);
  assign o_sync_drop     = drop_q;

endmodule
